// File: rtl/dm_write_tracer_if.sv
// Store-capture and drain-stream bundle between the core's data-memory write port, the tracer and its consumer.
// Latency: none, wiring only.
// Backpressure: the out_valid/out_ready pair carries the drain backpressure; the store side has none.
interface dm_write_tracer_if #(
    parameter int N     = 64,
    parameter int CNT_W = 16
);
    logic             DM_writeEnable;
    logic [N-1:0]     DM_addr;
    logic [N-1:0]     DM_writeData;
    logic             dump;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_addr;
    logic [N-1:0]     out_data;
    logic             out_last;
    logic [CNT_W-1:0] wr_count;
    logic             overflow;
    logic             busy;

    // Tracer side
    modport slave (
        input  DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
        output out_valid, out_addr, out_data, out_last, wr_count, overflow, busy
    );

    // Core, host and consumer side
    modport master (
        output DM_writeEnable, DM_addr, DM_writeData, dump, out_ready,
        input  out_valid, out_addr, out_data, out_last, wr_count, overflow, busy
    );
endinterface

// File: rtl/dm_write_tracer.sv
// Captures core stores into a DEPTH-entry FIFO and, on a dump rising edge, drains them in program order.
// Latency: the first out_valid comes one cycle after the dump edge is sampled; then one beat per cycle.
// Backpressure: out_valid with ~out_ready holds the head stable. Stores that arrive while the FIFO is full are dropped and flagged.
module dm_write_tracer #(
    parameter int N     = 64,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    dm_write_tracer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dump_q, dump_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             overflow_q, overflow_d;

    // Entry storage needs no reset: nothing is read unless occupancy covers it.
    logic [N-1:0]     fifo_addr_mem [DEPTH];
    logic [N-1:0]     fifo_data_mem [DEPTH];

    logic             dump_edge;
    logic             push;
    logic             pop;
    logic             out_valid;

    // Next state, FIFO control and counters
    always_comb begin
        state_d    = state_q;
        dump_d     = bus.dump;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        dump_edge  = bus.dump & ~dump_q;
        out_valid  = (state_q == S_DRAIN) && (cnt_q != '0);

        case (state_q)
            S_CAPTURE: begin
                if (bus.DM_writeEnable) begin
                    if (cnt_q != FULL_CNT) begin
                        push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (wr_count_q != {CNT_W{1'b1}}) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                end
                // A store in the edge cycle counts towards "non-empty".
                if (dump_edge) begin
                    state_d = ((cnt_q != '0) || push) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                pop = out_valid & bus.out_ready;
                if ((cnt_q == '0) || (pop && (cnt_q == (AW+1)'(1)))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Statistics of the finished trace are cleared only when the host lets go of dump.
                if (!bus.dump) begin
                    state_d    = S_CAPTURE;
                    wr_count_d = '0;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase

        // Push and pop live in disjoint states, so they never coincide.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q + 1'b1;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CAPTURE;
            dump_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dump_q     <= dump_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO entry write
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= bus.DM_addr;
            fifo_data_mem[wr_ptr_q] <= bus.DM_writeData;
        end
    end

    // Drain outputs are zero whenever no beat is offered.
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_valid ? fifo_addr_mem[rd_ptr_q] : '0;
    assign bus.out_data  = out_valid ? fifo_data_mem[rd_ptr_q] : '0;
    assign bus.out_last  = out_valid && (cnt_q == (AW+1)'(1));
    assign bus.wr_count  = wr_count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q != S_CAPTURE);
endmodule

// File: tb/tb_dm_write_tracer.sv
// Bench for dm_write_tracer: directed scenarios plus randomized capture/drain rounds.
// The reference model is a queue of expected (addr,data) pairs with a store count and an overflow flag.
// All inputs change and all outputs are sampled on the falling clock edge.
module tb_dm_write_tracer;
    localparam int N     = 64;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Reference model state
    logic [N-1:0] q_a[$];
    logic [N-1:0] q_d[$];
    int           m_cnt;
    bit           m_ovf;

    dm_write_tracer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    dm_write_tracer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic model_clear();
        q_a.delete();
        q_d.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_store(input logic [N-1:0] a, input logic [N-1:0] d);
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (q_a.size() < DEPTH) begin
            q_a.push_back(a);
            q_d.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
        bus.DM_writeEnable = 1'b1;
        bus.DM_addr        = a;
        bus.DM_writeData   = d;
        model_store(a, d);
        cyc();
        bus.DM_writeEnable = 1'b0;
    endtask

    // Random store activity during capture: strobe high on about half the cycles.
    task automatic random_capture(input int ncyc);
        logic [N-1:0] a;
        logic [N-1:0] d;
        for (int i = 0; i < ncyc; i++) begin
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            bus.DM_addr      = a;
            bus.DM_writeData = d;
            if ($urandom_range(0, 1) == 1) begin
                bus.DM_writeEnable = 1'b1;
                model_store(a, d);
            end else begin
                bus.DM_writeEnable = 1'b0;
            end
            cyc();
        end
        bus.DM_writeEnable = 1'b0;
        chk("wr_count_capture", 64'(bus.wr_count), 64'(m_cnt));
        chk("overflow_capture", 64'(bus.overflow), 64'(m_ovf));
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: the fixed toggle pattern, then 1.
    task automatic drain(input int mode, input bit edge_store, input bit drain_store);
        int n;
        bit rdy;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.dump = 1'b1;
        if (edge_store) begin
            bus.DM_writeEnable = 1'b1;
            bus.DM_addr        = 64'h20;
            bus.DM_writeData   = 64'h5;
            model_store(64'h20, 64'h5);
        end
        cyc();
        bus.DM_writeEnable = 1'b0;
        chk("busy_after_edge", 64'(bus.busy), 64'd1);
        n = 0;
        if (q_a.size() == 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("valid_empty_dump", 64'(bus.out_valid), 64'd0);
                cyc();
            end
        end
        while (q_a.size() > 0) begin
            if (drain_store && n == 0) begin
                bus.DM_writeEnable = 1'b1;
                bus.DM_addr        = 64'h28;
                bus.DM_writeData   = 64'h6;
            end else begin
                bus.DM_writeEnable = 1'b0;
            end
            if (mode == 0 || n > 200)  rdy = 1'b1;
            else if (mode == 2)        rdy = (n < 7) ? pat[n] : 1'b1;
            else                       rdy = ($urandom_range(0, 2) != 0);
            bus.out_ready = rdy;
            chk("out_valid", 64'(bus.out_valid), 64'd1);
            chk("out_addr", bus.out_addr, q_a[0]);
            chk("out_data", bus.out_data, q_d[0]);
            chk("out_last", 64'(bus.out_last), 64'(q_a.size() == 1));
            if (rdy) begin
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end
            n++;
            cyc();
        end
        bus.DM_writeEnable = 1'b0;
        chk("valid_after_drain", 64'(bus.out_valid), 64'd0);
        chk("addr_after_drain", bus.out_addr, 64'd0);
        chk("busy_done", 64'(bus.busy), 64'd1);
        chk("wr_count_done", 64'(bus.wr_count), 64'(m_cnt));
        chk("overflow_done", 64'(bus.overflow), 64'(m_ovf));
        bus.dump = 1'b0;
        cyc();
        model_clear();
        chk("busy_released", 64'(bus.busy), 64'd0);
        chk("wr_count_cleared", 64'(bus.wr_count), 64'd0);
        chk("overflow_cleared", 64'(bus.overflow), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        rst_n              = 1'b0;
        bus.DM_writeEnable = 1'b0;
        bus.DM_addr        = '0;
        bus.DM_writeData   = '0;
        bus.dump           = 1'b0;
        bus.out_ready      = 1'b0;

        // Reset state
        cyc();
        cyc();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_addr", bus.out_addr, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_wr_count", 64'(bus.wr_count), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Three stores, full-rate drain
        store(64'h08, 64'hA);
        store(64'h10, 64'hB);
        store(64'h18, 64'hC);
        chk("wr_count_three", 64'(bus.wr_count), 64'd3);
        drain(0, 1'b0, 1'b0);

        // Overflow: 18 stores into 16 entries
        for (int i = 0; i < 18; i++) store(64'(8 * i), 64'(i));
        chk("wr_count_18", 64'(bus.wr_count), 64'd18);
        chk("overflow_set", 64'(bus.overflow), 64'd1);
        drain(0, 1'b0, 1'b0);

        // Backpressure pattern on four entries
        for (int i = 0; i < 4; i++) store(64'(16'h100 + 8 * i), {$urandom, $urandom});
        drain(2, 1'b0, 1'b0);

        // Dump with an empty FIFO
        drain(0, 1'b0, 1'b0);

        // Store in the edge cycle is kept, store during drain is ignored
        drain(0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 5; i++) store(64'(16'h200 + 8 * i), 64'(i + 1));
        bus.dump = 1'b1;
        cyc();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_addr", bus.out_addr, q_a[0]);
            void'(q_a.pop_front());
            void'(q_d.pop_front());
            cyc();
        end
        #2 rst_n = 1'b0;
        bus.dump = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_addr", bus.out_addr, 64'd0);
        cyc();
        rst_n = 1'b1;
        model_clear();
        cyc();
        chk("post_rst_wr_count", 64'(bus.wr_count), 64'd0);
        store(64'h300, 64'h77);
        store(64'h308, 64'h78);
        drain(0, 1'b0, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            random_capture($urandom_range(0, 40));
            drain(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
